video_gain_offset_axis: RTL and testbench
=========================================

Name: video_gain_offset_axis

Overview:
Parametrised successor to the fixed-offset brightness stage in the ISP chain. It applies per-channel gain (contrast) and signed offset (brightness) with saturation to a multi-pixel-per-beat AXI-stream RGB video bus. Coefficients are run-time programmable and are applied only at frame boundaries. Backpressure propagates correctly through a 2-stage pipeline. It sits between the demosaic/colour stages and the video output formatter.

Parameters:
PPC, 4, pixels per beat
CW, 8, bits per colour channel; tdata width = PPC*3*CW
GAIN_W, 8, unsigned gain width
GAIN_FRAC, 6, gain fractional bits; unity = 1<<GAIN_FRAC = 64
OFS_W, 10, signed offset width, two's complement
DEF_GAIN, 64, gain applied after reset
DEF_OFS, 20, offset applied after reset

Ports:
I_clk  in  1  clock
I_rst  in  1  synchronous active-high reset
I_cfg_gain  in  GAIN_W  pending gain value
I_cfg_ofs  in  OFS_W  pending signed offset value
I_cfg_wr  in  1  1-cycle strobe; captures I_cfg_gain and I_cfg_ofs into the shadow registers
I_bypass  in  1  level; sampled with each accepted beat; 1 = pass pixels unmodified
I_tdata  in  PPC*3*CW  pixel p at [p*3*CW +: 3*CW], ordered {R,G,B}, B in the LSBs
I_tuser  in  1  start of frame
I_tlast  in  1  end of line
I_tvalid  in  1  input valid
I_tready  out  1  input ready
O_tdata  out  PPC*3*CW  processed pixels, same packing as input
O_tuser  out  1  delayed tuser
O_tlast  out  1  delayed tlast
O_tvalid  out  1  output valid
O_tready  in  1  downstream ready
O_cfg_pend  out  1  shadow registers hold values not yet applied
O_frame_cnt  out  16  count of accepted SOF beats; wraps

Behaviour:
- Reset: every stage valid = 0. O_tvalid = 0, O_tdata = 0, O_tuser = 0, O_tlast = 0, O_cfg_pend = 0, O_frame_cnt = 0. Active and shadow gain = DEF_GAIN; active and shadow offset = DEF_OFS.
- Reset asserted mid-frame: all in-flight beats are discarded with no flush. Outputs take their reset values on the next edge.
- Handshake: a beat transfers when valid & ready. Stage 2 enable en2 = O_tready | ~s2_valid. Stage 1 enable en1 = en2 | ~s1_valid. I_tready = en1, which is combinational from O_tready.
- Latency: 2 cycles from input accept to O_tvalid when there is no stall.
- Data, tuser and tlast are never dropped or duplicated. O_tdata is held stable while O_tvalid & ~O_tready.
- Throughput: 1 beat/clk at sustained O_tready = 1.
- Config:
  - I_cfg_wr loads the shadow registers and sets O_cfg_pend = 1.
  - On an accepted input beat with I_tuser = 1: if pend, active <= shadow and pend clears. That beat and every later beat use the new coefficients. O_frame_cnt increments on the same beat.
  - If I_cfg_wr coincides with an accepted SOF beat: the shadow captures the new values, the SOF beat uses the old shadow, and pend stays 1.
  - Mid-frame writes never change the active coefficients.
- Coefficients and bypass are sampled with each beat in stage 1 and travel with the beat.
- Stage 1 arithmetic, per channel: prod = x * gain, unsigned, CW+GAIN_W bits; s = prod >> GAIN_FRAC, truncated.
- Stage 2 arithmetic:
  - sum = s + sign-extended ofs, signed, CW+GAIN_W+2 bits.
  - Saturate: sum < 0 -> 0; sum > 2^CW-1 -> 2^CW-1; otherwise sum[CW-1:0].
  - Bypass beat: the output equals the input channel unchanged.

Decomposition:
- Shared package isp_pkg: the pixel packing helper functions (channel index to bit offset) and the unity-gain constant function (1<<GAIN_FRAC).
- Sub-module gain_offset_ch: one channel with the 2-stage arithmetic and the en1/en2 inputs. It is instantiated PPC*3 times via generate.
- Top level holds the valid/ready control, shadow/active registers, sideband pipeline and frame counter.

Test Plan:
- Reset defaults, unity gain (CW=8, PPC=4): input channel 100 -> 120; 250 -> 255 (clamp high). Output appears 2 cycles after accept. O_frame_cnt = 0.
- cfg_wr gain = 128, ofs = -300 issued mid-frame: beats stay on the old coefficients and O_cfg_pend = 1. On the next SOF beat: 200 -> 200*2 - 300 = 100; 100 -> 0 (clamp low). O_cfg_pend = 0 and O_frame_cnt = 1.
- cfg_wr in the same cycle as an accepted SOF: that frame uses the previous shadow. O_cfg_pend remains 1, and the new values apply at the following SOF.
- Random O_tready (50%) with random I_tvalid over 3 frames of 8 lines x 16 beats: the scoreboard matches every beat in order, tuser/tlast are aligned, and O_tdata is stable during stalls.
- I_bypass = 1 on alternating beats with gain = 32, ofs = 5: bypass beats are identical to the input; other beats give 100 -> 55.
- Reset asserted with 2 beats in flight under stall: O_tvalid = 0 on the next edge. Active coefficients return to DEF_GAIN/DEF_OFS and O_frame_cnt = 0.

Source files
------------

// File: rtl/isp_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | isp_pkg                                                               |
// | Shared ISP helpers: pixel/channel packing and unity-gain constant.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package isp_pkg;

    localparam int CH_PER_PIX = 3;

    // Sideband bits that travel alongside each beat through the pipeline.
    typedef struct packed {
        logic user;
        logic last;
    } side_t;

    // Channel 0 = B (LSBs), 1 = G, 2 = R; pixels packed upward from bit 0.
    function automatic int chan_lsb(input int cw, input int pix, input int ch);
        return (pix * CH_PER_PIX + ch) * cw;
    endfunction

    function automatic int unity_gain(input int frac);
        return 1 << frac;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gain_offset_ch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | gain_offset_ch                                                        |
// | One colour channel: stage 1 gain multiply, stage 2 offset + clamp.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module gain_offset_ch #(
    parameter int CW        = 8,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 6,
    parameter int OFS_W     = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en1_i,
    input  logic              en2_i,
    input  logic [CW-1:0]     x_i,
    input  logic [GAIN_W-1:0] gain_i,
    input  logic [OFS_W-1:0]  ofs_i,
    input  logic              byp_i,
    output logic [CW-1:0]     y_o
);

    localparam int PW = CW + GAIN_W;
    localparam int SW = PW + 2;

    logic [PW-1:0]        prod_w;
    logic [PW-1:0]        s_d, s_q;
    logic [OFS_W-1:0]     ofs_q;
    logic                 byp_q;
    logic signed [SW-1:0] sum_w;
    logic [CW-1:0]        y_d, y_q;

    assign prod_w = PW'(x_i) * PW'(gain_i);

    // A bypass beat carries the raw pixel through the stage-1 register.
    always_comb begin
        s_d = prod_w >> GAIN_FRAC;
        if (byp_i) begin
            s_d = PW'(x_i);
        end
    end

    assign sum_w = $signed({2'b00, s_q}) + $signed({{(SW-OFS_W){ofs_q[OFS_W-1]}}, ofs_q});

    always_comb begin
        y_d = sum_w[CW-1:0];
        if (byp_q) begin
            y_d = s_q[CW-1:0];
        end else if (sum_w[SW-1]) begin
            y_d = '0;
        end else if (|sum_w[SW-2:CW]) begin
            y_d = '1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q   <= '0;
            ofs_q <= '0;
            byp_q <= 1'b0;
            y_q   <= '0;
        end else begin
            if (en1_i) begin
                s_q   <= s_d;
                ofs_q <= ofs_i;
                byp_q <= byp_i;
            end
            if (en2_i) begin
                y_q <= y_d;
            end
        end
    end

    assign y_o = y_q;

endmodule
`default_nettype wire

// File: rtl/video_gain_offset_axis.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | video_gain_offset_axis                                                |
// | Per-channel gain/offset with saturation on a multi-pixel AXI stream.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module video_gain_offset_axis
    import isp_pkg::*;
#(
    parameter int PPC       = 4,
    parameter int CW        = 8,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 6,
    parameter int OFS_W     = 10,
    parameter int DEF_GAIN  = unity_gain(GAIN_FRAC),
    parameter int DEF_OFS   = 20
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic [GAIN_W-1:0]     I_cfg_gain,
    input  logic [OFS_W-1:0]      I_cfg_ofs,
    input  logic                  I_cfg_wr,
    input  logic                  I_bypass,
    input  logic [PPC*3*CW-1:0]   I_tdata,
    input  logic                  I_tuser,
    input  logic                  I_tlast,
    input  logic                  I_tvalid,
    output logic                  I_tready,
    output logic [PPC*3*CW-1:0]   O_tdata,
    output logic                  O_tuser,
    output logic                  O_tlast,
    output logic                  O_tvalid,
    input  logic                  O_tready,
    output logic                  O_cfg_pend,
    output logic [15:0]           O_frame_cnt
);

    localparam logic [GAIN_W-1:0] RST_GAIN = GAIN_W'(DEF_GAIN);
    localparam logic [OFS_W-1:0]  RST_OFS  = OFS_W'(DEF_OFS);

    logic en1, en2, acc, sof_acc, apply, ld2;
    logic [GAIN_W-1:0] gain_eff;
    logic [OFS_W-1:0]  ofs_eff;

    logic              s1_valid_d, s1_valid_q;
    logic              s2_valid_d, s2_valid_q;
    side_t             s1_side_d, s1_side_q;
    side_t             s2_side_d, s2_side_q;
    logic [GAIN_W-1:0] gain_act_d, gain_act_q, gain_shd_d, gain_shd_q;
    logic [OFS_W-1:0]  ofs_act_d, ofs_act_q, ofs_shd_d, ofs_shd_q;
    logic              pend_d, pend_q;
    logic [15:0]       frame_cnt_d, frame_cnt_q;

    assign en2     = O_tready | ~s2_valid_q;
    assign en1     = en2 | ~s1_valid_q;
    assign acc     = I_tvalid & en1;
    assign ld2     = en2 & s1_valid_q;
    assign sof_acc = acc & I_tuser;
    assign apply   = sof_acc & pend_q;

    // The SOF beat that commits the shadow already uses the new values.
    assign gain_eff = apply ? gain_shd_q : gain_act_q;
    assign ofs_eff  = apply ? ofs_shd_q  : ofs_act_q;

    always_comb begin
        s1_valid_d  = en1 ? I_tvalid : s1_valid_q;
        s2_valid_d  = en2 ? s1_valid_q : s2_valid_q;
        s1_side_d   = acc ? side_t'({I_tuser, I_tlast}) : s1_side_q;
        s2_side_d   = ld2 ? s1_side_q : s2_side_q;
        gain_shd_d  = I_cfg_wr ? I_cfg_gain : gain_shd_q;
        ofs_shd_d   = I_cfg_wr ? I_cfg_ofs  : ofs_shd_q;
        gain_act_d  = apply ? gain_shd_q : gain_act_q;
        ofs_act_d   = apply ? ofs_shd_q  : ofs_act_q;
        pend_d      = I_cfg_wr ? 1'b1 : (apply ? 1'b0 : pend_q);
        frame_cnt_d = sof_acc ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s1_side_q   <= '0;
            s2_side_q   <= '0;
            gain_act_q  <= RST_GAIN;
            gain_shd_q  <= RST_GAIN;
            ofs_act_q   <= RST_OFS;
            ofs_shd_q   <= RST_OFS;
            pend_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s1_side_q   <= s1_side_d;
            s2_side_q   <= s2_side_d;
            gain_act_q  <= gain_act_d;
            gain_shd_q  <= gain_shd_d;
            ofs_act_q   <= ofs_act_d;
            ofs_shd_q   <= ofs_shd_d;
            pend_q      <= pend_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    for (genvar gp = 0; gp < PPC; gp++) begin : g_pix
        for (genvar gc = 0; gc < CH_PER_PIX; gc++) begin : g_ch
            localparam int LSB = chan_lsb(CW, gp, gc);
            gain_offset_ch #(
                .CW        (CW),
                .GAIN_W    (GAIN_W),
                .GAIN_FRAC (GAIN_FRAC),
                .OFS_W     (OFS_W)
            ) u_ch (
                .clk_i  (I_clk),
                .rst_i  (I_rst),
                .en1_i  (acc),
                .en2_i  (ld2),
                .x_i    (I_tdata[LSB +: CW]),
                .gain_i (gain_eff),
                .ofs_i  (ofs_eff),
                .byp_i  (I_bypass),
                .y_o    (O_tdata[LSB +: CW])
            );
        end
    end

    assign I_tready    = en1;
    assign O_tvalid    = s2_valid_q;
    assign O_tuser     = s2_side_q.user;
    assign O_tlast     = s2_side_q.last;
    assign O_cfg_pend  = pend_q;
    assign O_frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_video_gain_offset_axis.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_video_gain_offset_axis                                             |
// | Directed and randomised-handshake checks of video_gain_offset_axis.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_video_gain_offset_axis;

    localparam int NCH    = 12;
    localparam int DW     = 96;
    localparam int N_RAND = 384;

    logic          clk = 1'b0;
    logic          I_rst = 1'b1;
    logic [7:0]    I_cfg_gain = '0;
    logic [9:0]    I_cfg_ofs = '0;
    logic          I_cfg_wr = 1'b0;
    logic          I_bypass = 1'b0;
    logic [DW-1:0] I_tdata = '0;
    logic          I_tuser = 1'b0;
    logic          I_tlast = 1'b0;
    logic          I_tvalid = 1'b0;
    logic          I_tready;
    logic [DW-1:0] O_tdata;
    logic          O_tuser, O_tlast, O_tvalid;
    logic          O_tready = 1'b0;
    logic          O_cfg_pend;
    logic [15:0]   O_frame_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
        logic          chg;
    } obeat_t;
    obeat_t out_q[$];

    logic          prev_stall = 1'b0;
    logic          chg = 1'b0;
    logic [DW-1:0] h_d = '0;
    logic          h_u = 1'b0, h_l = 1'b0;

    logic [DW-1:0] sd[N_RAND];
    logic [DW-1:0] ed[N_RAND];
    logic          su[N_RAND], sl[N_RAND], sb[N_RAND];

    video_gain_offset_axis dut (
        .I_clk       (clk),
        .I_rst       (I_rst),
        .I_cfg_gain  (I_cfg_gain),
        .I_cfg_ofs   (I_cfg_ofs),
        .I_cfg_wr    (I_cfg_wr),
        .I_bypass    (I_bypass),
        .I_tdata     (I_tdata),
        .I_tuser     (I_tuser),
        .I_tlast     (I_tlast),
        .I_tvalid    (I_tvalid),
        .I_tready    (I_tready),
        .O_tdata     (O_tdata),
        .O_tuser     (O_tuser),
        .O_tlast     (O_tlast),
        .O_tvalid    (O_tvalid),
        .O_tready    (O_tready),
        .O_cfg_pend  (O_cfg_pend),
        .O_frame_cnt (O_frame_cnt)
    );

    always #5 clk = ~clk;

    // Output collector; chg marks a beat whose data moved while stalled.
    always @(negedge clk) begin
        if (I_rst) begin
            prev_stall = 1'b0;
            chg = 1'b0;
        end else begin
            if (prev_stall && (!O_tvalid || O_tdata !== h_d || O_tuser !== h_u || O_tlast !== h_l))
                chg = 1'b1;
            if (O_tvalid && O_tready) begin
                out_q.push_back('{O_tdata, O_tuser, O_tlast, chg});
                chg = 1'b0;
                prev_stall = 1'b0;
            end else if (O_tvalid) begin
                prev_stall = 1'b1;
                h_d = O_tdata;
                h_u = O_tuser;
                h_l = O_tlast;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    function automatic logic [DW-1:0] fill(input logic [7:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [7:0] mdl(input logic [7:0] x, input int g, input int o, input logic b);
        int v;
        if (b) return x;
        v = (int'(x) * g) / 64 + o;
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    task automatic cfg_write(input logic [7:0] g, input logic [9:0] o);
        I_cfg_gain = g;
        I_cfg_ofs  = o;
        I_cfg_wr   = 1'b1;
        @(posedge clk); #1;
        I_cfg_wr   = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic u, input logic l, input logic b,
                        input logic cw, input logic [7:0] g, input logic [9:0] o);
        int n = 0;
        I_tdata = d; I_tuser = u; I_tlast = l; I_bypass = b; I_tvalid = 1'b1;
        if (cw) begin
            I_cfg_wr = 1'b1; I_cfg_gain = g; I_cfg_ofs = o;
        end
        @(negedge clk);
        while (!I_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: tready stayed %b, required 1", I_tready);
        end
        @(posedge clk); #1;
        I_tvalid = 1'b0; I_cfg_wr = 1'b0; I_tuser = 1'b0; I_tlast = 1'b0; I_bypass = 1'b0;
    endtask

    task automatic test_reset();
        I_rst = 1'b1;
        O_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (O_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b required 0", O_tvalid); end
        checks++; if (O_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h required 0", O_tdata); end
        checks++; if ({O_tuser, O_tlast} !== 2'b00) begin errors++; $display("FAIL reset_side: got %b%b required 00", O_tuser, O_tlast); end
        checks++; if (O_cfg_pend !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b required 0", O_cfg_pend); end
        checks++; if (O_frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d required 0", O_frame_cnt); end
        checks++; if (I_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b required 1", I_tready); end
        I_rst = 1'b0;
        @(posedge clk); #1;
        O_tready = 1'b1;
    endtask

    task automatic test_unity();
        logic [DW-1:0] d, e;
        int cyc;
        d = fill(8'd100); d[7:0] = 8'd250;
        e = fill(8'd120); e[7:0] = 8'd255;
        send(d, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 10'd0);
        cyc = 1;
        while (!O_tvalid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc != 2) begin errors++; $display("FAIL unity_latency: got %0d required 2", cyc); end
        checks++; if (O_tdata !== e) begin errors++; $display("FAIL unity_data: got %h required %h", O_tdata, e); end
        checks++; if ({O_tuser, O_tlast} !== 2'b01) begin errors++; $display("FAIL unity_side: got %b%b required 01", O_tuser, O_tlast); end
        checks++; if (O_frame_cnt !== 16'd0) begin errors++; $display("FAIL unity_frame_cnt: got %0d required 0", O_frame_cnt); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_cfg_midframe();
        logic [DW-1:0] d, e;
        out_q.delete();
        cfg_write(8'd128, 10'(-300));
        checks++; if (O_cfg_pend !== 1'b1) begin errors++; $display("FAIL mid_pend_set: got %b required 1", O_cfg_pend); end
        send(fill(8'd100), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0);
        d = fill(8'd200); d[7:0] = 8'd100;
        e = fill(8'd100); e[7:0] = 8'd0;
        send(d, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0);
        checks++; if (O_cfg_pend !== 1'b0) begin errors++; $display("FAIL mid_pend_clear: got %b required 0", O_cfg_pend); end
        checks++; if (O_frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_frame_cnt: got %0d required 1", O_frame_cnt); end
        send(fill(8'd180), 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 10'd0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_q.size() != 3) begin errors++; $display("FAIL mid_count: got %0d required 3", out_q.size()); end
        if (out_q.size() >= 3) begin
            checks++; if (out_q[0].d !== fill(8'd120)) begin errors++; $display("FAIL mid_old_coef: got %h required %h", out_q[0].d, fill(8'd120)); end
            checks++; if (out_q[1].d !== e || out_q[1].u !== 1'b1) begin errors++; $display("FAIL mid_sof_new: got %h u=%b required %h u=1", out_q[1].d, out_q[1].u, e); end
            checks++; if (out_q[2].d !== fill(8'd60) || out_q[2].l !== 1'b1) begin errors++; $display("FAIL mid_after_sof: got %h l=%b required %h l=1", out_q[2].d, out_q[2].l, fill(8'd60)); end
        end
    endtask

    task automatic test_cfg_coincident();
        logic [DW-1:0] d, e;
        out_q.delete();
        cfg_write(8'd64, 10'd0);
        checks++; if (O_cfg_pend !== 1'b1) begin errors++; $display("FAIL coin_pend_set: got %b required 1", O_cfg_pend); end
        d = fill(8'd100); d[7:0] = 8'd250;
        e = fill(8'd55);  e[7:0] = 8'd130;
        send(d, 1'b1, 1'b0, 1'b0, 1'b1, 8'd32, 10'd5);
        checks++; if (O_cfg_pend !== 1'b1) begin errors++; $display("FAIL coin_pend_kept: got %b required 1", O_cfg_pend); end
        checks++; if (O_frame_cnt !== 16'd2) begin errors++; $display("FAIL coin_frame_cnt: got %0d required 2", O_frame_cnt); end
        send(fill(8'd100), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0);
        send(d, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0);
        checks++; if (O_cfg_pend !== 1'b0 || O_frame_cnt !== 16'd3) begin errors++; $display("FAIL coin_second_sof: pend=%b cnt=%0d required pend=0 cnt=3", O_cfg_pend, O_frame_cnt); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_q.size() != 3) begin errors++; $display("FAIL coin_count: got %0d required 3", out_q.size()); end
        if (out_q.size() >= 3) begin
            checks++; if (out_q[0].d !== d) begin errors++; $display("FAIL coin_old_shadow: got %h required %h", out_q[0].d, d); end
            checks++; if (out_q[1].d !== fill(8'd100)) begin errors++; $display("FAIL coin_mid: got %h required %h", out_q[1].d, fill(8'd100)); end
            checks++; if (out_q[2].d !== e) begin errors++; $display("FAIL coin_new_shadow: got %h required %h", out_q[2].d, e); end
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] d, e;
        out_q.delete();
        d = fill(8'd100); d[7:0] = 8'd7;
        e = fill(8'd55);  e[7:0] = 8'd8;
        for (int i = 0; i < 4; i++) send(d, 1'b0, (i == 3), (i % 2 == 0), 1'b0, 8'd0, 10'd0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL byp_count: got %0d required 4", out_q.size()); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i].d !== ((i % 2 == 0) ? d : e)) begin
                errors++;
                $display("FAIL byp_beat%0d: got %h required %h", i, out_q[i].d, (i % 2 == 0) ? d : e);
            end
        end
    endtask

    task automatic test_random();
        int idx = 0;
        int cyc = 0;
        logic acc;
        logic [7:0] x;
        out_q.delete();
        cfg_write(8'd160, 10'(-40));
        for (int k = 0; k < N_RAND; k++) begin
            su[k] = (k % 128 == 0);
            sl[k] = (k % 16 == 15);
            sb[k] = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < NCH; c++) begin
                x = 8'($urandom_range(0, 255));
                sd[k][c*8 +: 8] = x;
                ed[k][c*8 +: 8] = mdl(x, 160, -40, sb[k]);
            end
        end
        while ((idx < N_RAND || out_q.size() < N_RAND) && cyc < 20000) begin
            O_tready = 1'($urandom_range(0, 1));
            if (!I_tvalid && idx < N_RAND && $urandom_range(0, 1) == 1) begin
                I_tdata = sd[idx]; I_tuser = su[idx]; I_tlast = sl[idx]; I_bypass = sb[idx];
                I_tvalid = 1'b1;
            end
            @(negedge clk);
            acc = I_tvalid && I_tready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                idx++;
                I_tvalid = 1'b0;
            end
        end
        O_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cyc >= 20000) begin errors++; $display("FAIL rand_timeout: sent %0d got %0d required %0d", idx, out_q.size(), N_RAND); end
        checks++; if (out_q.size() != N_RAND) begin errors++; $display("FAIL rand_count: got %0d required %0d", out_q.size(), N_RAND); end
        for (int k = 0; k < N_RAND && k < out_q.size(); k++) begin
            checks++;
            if ({out_q[k].d, out_q[k].u, out_q[k].l} !== {ed[k], su[k], sl[k]}) begin
                errors++;
                $display("FAIL rand_beat%0d: got %h u=%b l=%b required %h u=%b l=%b", k, out_q[k].d, out_q[k].u, out_q[k].l, ed[k], su[k], sl[k]);
            end
            checks++;
            if (out_q[k].chg !== 1'b0) begin
                errors++;
                $display("FAIL rand_stall_hold%0d: changed=%b required 0", k, out_q[k].chg);
            end
        end
        checks++; if (O_frame_cnt !== 16'd6) begin errors++; $display("FAIL rand_frame_cnt: got %0d required 6", O_frame_cnt); end
    endtask

    task automatic test_reset_inflight();
        cfg_write(8'd200, 10'd100);
        O_tready = 1'b0;
        send(fill(8'd1), 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0);
        send(fill(8'd2), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0);
        checks++; if (O_tvalid !== 1'b1 || I_tready !== 1'b0) begin errors++; $display("FAIL rst_prestate: tvalid=%b tready=%b required 1 0", O_tvalid, I_tready); end
        I_rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (O_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b required 0", O_tvalid); end
        checks++; if (O_tdata !== '0) begin errors++; $display("FAIL rst_tdata: got %h required 0", O_tdata); end
        checks++; if (O_frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d required 0", O_frame_cnt); end
        checks++; if (O_cfg_pend !== 1'b0) begin errors++; $display("FAIL rst_pend: got %b required 0", O_cfg_pend); end
        I_rst = 1'b0;
        O_tready = 1'b1;
        @(posedge clk); #1;
        out_q.delete();
        send(fill(8'd100), 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_q.size() != 1) begin errors++; $display("FAIL rst_count: got %0d required 1", out_q.size()); end
        if (out_q.size() >= 1) begin
            checks++; if (out_q[0].d !== fill(8'd120)) begin errors++; $display("FAIL rst_default_coef: got %h required %h", out_q[0].d, fill(8'd120)); end
        end
        checks++; if (O_frame_cnt !== 16'd1) begin errors++; $display("FAIL rst_frame_cnt_after: got %0d required 1", O_frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_cfg_midframe();
        test_cfg_coincident();
        test_bypass();
        test_random();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
